// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed program image over 8N1 serial,
// writes it word by word into instruction memory, then releases the core.
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          MAX_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_bit,
    output logic        imem_wr,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        boot_done,
    output logic        frame_err,
    output logic        len_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_LEN, LD_LOAD, LD_DONE, LD_ERROR} ld_state_t;

    logic          rx_meta, rx_sync;
    rx_state_t     rx_state, rx_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift, shift_next;
    logic          stop_bad;

    // Receiver -> loader handshake: byte_valid is a one-cycle pulse carrying
    // byte_data; there is no ready, the loader accepts every pulse it sees.
    logic          byte_valid;
    logic [7:0]    byte_data;

    ld_state_t     ld_state, ld_next;
    logic [1:0]    byte_cnt, byte_cnt_next;
    logic [31:0]   asm_reg, asm_next;
    logic [31:0]   word_count, count_next;
    logic [31:0]   index, index_next;
    logic [31:0]   word_in;
    logic          wr_fire;
    logic          len_bad;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_bit;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            rx_state <= rx_next;
            timer    <= timer_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
        end
    end

    // Samples land near mid-bit: half a bit after the start edge, then one full bit apart.
    always_comb begin
        rx_next    = rx_state;
        timer_next = timer + 1'b1;
        bit_next   = bit_cnt;
        shift_next = shift;
        byte_valid = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                timer_next = '0;
                if (!rx_sync) rx_next = RX_START;
            end
            RX_START: begin
                if (timer == HALF_T) begin
                    timer_next = '0;
                    bit_next   = '0;
                    rx_next    = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (timer == FULL_T) begin
                    timer_next = '0;
                    shift_next = {rx_sync, shift[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (timer == FULL_T) begin
                    timer_next = '0;
                    rx_next    = RX_IDLE;
                    if (rx_sync) byte_valid = 1'b1;
                    else         stop_bad   = 1'b1;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    assign byte_data = shift;

    always_ff @(posedge clock) begin
        if (reset) begin
            ld_state   <= LD_LEN;
            byte_cnt   <= '0;
            asm_reg    <= '0;
            word_count <= '0;
            index      <= '0;
        end else begin
            ld_state   <= ld_next;
            byte_cnt   <= byte_cnt_next;
            asm_reg    <= asm_next;
            word_count <= count_next;
            index      <= index_next;
        end
    end

    // Bytes shift in from the top so the first byte ends up in bits 7:0.
    always_comb begin
        ld_next       = ld_state;
        byte_cnt_next = byte_cnt;
        asm_next      = asm_reg;
        count_next    = word_count;
        index_next    = index;
        wr_fire       = 1'b0;
        len_bad       = 1'b0;
        word_in       = {byte_data, asm_reg[31:8]};
        if (byte_valid && (ld_state == LD_LEN || ld_state == LD_LOAD)) begin
            asm_next      = word_in;
            byte_cnt_next = byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
                if (ld_state == LD_LEN) begin
                    count_next = word_in;
                    index_next = '0;
                    if (word_in == 32'd0) begin
                        ld_next = LD_DONE;
                    end else if (word_in > 32'(MAX_WORDS)) begin
                        ld_next = LD_ERROR;
                        len_bad = 1'b1;
                    end else begin
                        ld_next = LD_LOAD;
                    end
                end else begin
                    wr_fire    = 1'b1;
                    index_next = index + 32'd1;
                    if (index + 32'd1 == word_count) ld_next = LD_DONE;
                end
            end
        end
        core_reset = (ld_state != LD_DONE);
        boot_done  = (ld_state == LD_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            imem_wr    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            frame_err  <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            imem_wr <= wr_fire;
            if (wr_fire) begin
                imem_addr  <= BASE_ADDR + {index[29:0], 2'b00};
                imem_wdata <= word_in;
            end
            frame_err <= frame_err | stop_bad;
            len_err   <= len_err | len_bad;
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed scenario table, hand-timed corner cases,
// and random images checked against a byte-stream reference model.
module tb_uart_boot_loader;

    localparam int CPB  = 4;
    localparam int MAXW = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_bit;
    logic        imem_wr;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        boot_done;
    logic        frame_err;
    logic        len_err;

    uart_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (MAXW),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_bit    (rx_bit),
        .imem_wr   (imem_wr),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .boot_done (boot_done),
        .frame_err (frame_err),
        .len_err   (len_err)
    );

    always #5 clock = ~clock;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] exp_q[$];
    logic [1:0]  exp_flag_q[$];
    logic [63:0] obs_q[$];
    logic [1:0]  obs_flag_q[$];
    logic [7:0]  stim_b[$];
    bit          stim_s[$];
    bit          exp_done, exp_ferr, exp_lerr;

    typedef struct {
        logic [127:0] bytes;
        int           nbytes;
        logic [15:0]  bad;
        bit           glitch;
        int           nwr;
        logic [63:0]  wdata;
        bit           done;
        bit           ferr;
        bit           lerr;
    } vec_t;

    vec_t  tbl[6];
    string names[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Advance one clock; outputs are sampled on the falling edge.
    task automatic tick;
        @(negedge clock);
        if (imem_wr === 1'b1) begin
            obs_q.push_back({imem_addr, imem_wdata});
            obs_flag_q.push_back({boot_done, core_reset});
        end
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        rx_bit = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        obs_q.delete();
        obs_flag_q.delete();
    endtask

    task automatic send_bits(input logic [7:0] b);
        rx_bit = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx_bit = b[i];
            repeat (CPB) tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        send_bits(b);
        rx_bit = stop_ok;
        repeat (CPB) tick();
        rx_bit = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_stim;
        foreach (stim_b[i]) send_byte(stim_b[i], stim_s[i]);
        repeat (8) tick();
    endtask

    task automatic push_good(input logic [7:0] b);
        if ($urandom_range(0, 7) == 0) begin
            stim_b.push_back(8'($urandom_range(0, 255)));
            stim_s.push_back(1'b0);
        end
        stim_b.push_back(b);
        stim_s.push_back(1'b1);
    endtask

    // Reference: drop framing-error bytes, read a little-endian length, then words.
    task automatic run_model;
        logic [7:0]  g[$];
        logic [31:0] n;
        logic [31:0] w;
        int          nw;
        bit          last;
        exp_q.delete();
        exp_flag_q.delete();
        exp_done = 1'b0;
        exp_ferr = 1'b0;
        exp_lerr = 1'b0;
        foreach (stim_b[i]) begin
            if (stim_s[i]) g.push_back(stim_b[i]);
            else           exp_ferr = 1'b1;
        end
        if (g.size() >= 4) begin
            n = {g[3], g[2], g[1], g[0]};
            if (n == 0) begin
                exp_done = 1'b1;
            end else if (n > MAXW) begin
                exp_lerr = 1'b1;
            end else begin
                nw = (g.size() - 4) / 4;
                if (nw > int'(n)) nw = int'(n);
                for (int k = 0; k < nw; k++) begin
                    w = {g[4*k+7], g[4*k+6], g[4*k+5], g[4*k+4]};
                    last = (k == int'(n) - 1);
                    exp_q.push_back({32'(4 * k), w});
                    exp_flag_q.push_back({last, !last});
                end
                exp_done = (nw == int'(n));
            end
        end
    endtask

    task automatic compare_results(input string name);
        logic [63:0] o, e;
        logic [1:0]  of, ef;
        check({name, " write_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o  = obs_q.pop_front();
            e  = exp_q.pop_front();
            of = obs_flag_q.pop_front();
            ef = exp_flag_q.pop_front();
            check({name, " write addr/data"}, o, e);
            check({name, " done/core_reset at strobe"}, 64'(of), 64'(ef));
        end
        check({name, " boot_done"},  64'(boot_done),  64'(exp_done));
        check({name, " core_reset"}, 64'(core_reset), 64'(!exp_done));
        check({name, " frame_err"},  64'(frame_err),  64'(exp_ferr));
        check({name, " len_err"},    64'(len_err),    64'(exp_lerr));
        obs_q.delete();
        obs_flag_q.delete();
        exp_q.delete();
        exp_flag_q.delete();
    endtask

    task automatic check_reset_values(input string name);
        check({name, " imem_wr"},    64'(imem_wr),    64'(0));
        check({name, " imem_addr"},  64'(imem_addr),  64'(0));
        check({name, " imem_wdata"}, 64'(imem_wdata), 64'(0));
        check({name, " core_reset"}, 64'(core_reset), 64'(1));
        check({name, " boot_done"},  64'(boot_done),  64'(0));
        check({name, " frame_err"},  64'(frame_err),  64'(0));
        check({name, " len_err"},    64'(len_err),    64'(0));
    endtask

    task automatic load_stream(input logic [127:0] bytes, input int nbytes);
        stim_b.delete();
        stim_s.delete();
        for (int i = 0; i < nbytes; i++) begin
            stim_b.push_back(bytes[8*i +: 8]);
            stim_s.push_back(1'b1);
        end
    endtask

    initial begin
        logic [31:0] n;
        logic [31:0] w;
        bool_dummy: begin end
        reset  = 1'b1;
        rx_bit = 1'b1;

        // Byte streams are written LSB-first: byte 0 is bits 7:0.
        names[0] = "two_words";
        tbl[0] = '{bytes: 128'h00000013_00500093_00000002, nbytes: 12, bad: 16'h0, glitch: 1'b0,
                   nwr: 2, wdata: 64'h00000013_00500093, done: 1'b1, ferr: 1'b0, lerr: 1'b0};
        names[1] = "zero_len";
        tbl[1] = '{bytes: 128'h0, nbytes: 4, bad: 16'h0, glitch: 1'b0,
                   nwr: 0, wdata: 64'h0, done: 1'b1, ferr: 1'b0, lerr: 1'b0};
        names[2] = "glitch";
        tbl[2] = '{bytes: 128'h00000013_00500093_00000002, nbytes: 12, bad: 16'h0, glitch: 1'b1,
                   nwr: 2, wdata: 64'h00000013_00500093, done: 1'b1, ferr: 1'b0, lerr: 1'b0};
        names[3] = "frame_drop";
        tbl[3] = '{bytes: 128'h00_50_00_93_93_00000001, nbytes: 9, bad: 16'h0010, glitch: 1'b0,
                   nwr: 1, wdata: 64'h00500093, done: 1'b1, ferr: 1'b1, lerr: 1'b0};
        names[4] = "len_1025";
        tbl[4] = '{bytes: 128'h88776655_44332211_00000401, nbytes: 12, bad: 16'h0, glitch: 1'b0,
                   nwr: 0, wdata: 64'h0, done: 1'b0, ferr: 1'b0, lerr: 1'b1};
        names[5] = "len_1024";
        tbl[5] = '{bytes: 128'hDEADBEEF_00000400, nbytes: 8, bad: 16'h0, glitch: 1'b0,
                   nwr: 1, wdata: 64'hDEADBEEF, done: 1'b0, ferr: 1'b0, lerr: 1'b0};

        do_reset();
        check_reset_values("reset");

        for (int t = 0; t < 6; t++) begin
            do_reset();
            if (tbl[t].glitch) begin
                rx_bit = 1'b0;
                tick();
                rx_bit = 1'b1;
                repeat (8) tick();
            end
            for (int i = 0; i < tbl[t].nbytes; i++)
                send_byte(tbl[t].bytes[8*i +: 8], !tbl[t].bad[i]);
            repeat (8) tick();
            exp_q.delete();
            exp_flag_q.delete();
            for (int i = 0; i < tbl[t].nwr; i++) begin
                exp_q.push_back({32'(4 * i), tbl[t].wdata[32*i +: 32]});
                exp_flag_q.push_back({tbl[t].done && i == tbl[t].nwr - 1,
                                      !(tbl[t].done && i == tbl[t].nwr - 1)});
            end
            exp_done = tbl[t].done;
            exp_ferr = tbl[t].ferr;
            exp_lerr = tbl[t].lerr;
            compare_results(names[t]);
        end

        // Zero-length image: release lands exactly one cycle after the stop sample.
        do_reset();
        repeat (3) send_byte(8'h00, 1'b1);
        send_bits(8'h00);
        rx_bit = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("zero_len_timing boot_done k=%0d", k), 64'(boot_done), 64'(k == 5));
            check($sformatf("zero_len_timing core_reset k=%0d", k), 64'(core_reset), 64'(k != 5));
        end
        repeat (6) tick();
        check("zero_len_timing writes", 64'(obs_q.size()), 64'(0));

        // Reset mid-image and mid-byte, then a full reload.
        do_reset();
        load_stream(128'h00000013_00500093_00000002, 12);
        for (int i = 0; i < 10; i++) send_byte(stim_b[i], 1'b1);
        send_bits(8'h5A);
        check("midreset first write seen", 64'(obs_q.size()), 64'(1));
        do_reset();
        check_reset_values("midreset");
        send_stim();
        run_model();
        compare_results("midreset reload");

        // Random images, with occasional dropped bytes and oversize lengths.
        for (int r = 0; r < 15; r++) begin
            do_reset();
            stim_b.delete();
            stim_s.delete();
            if ($urandom_range(0, 5) == 0) n = 32'(MAXW + 1 + $urandom_range(0, 3000));
            else                           n = 32'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) push_good(n[8*i +: 8]);
            if (n <= MAXW) begin
                for (int k = 0; k < int'(n); k++) begin
                    w = $urandom();
                    for (int i = 0; i < 4; i++) push_good(w[8*i +: 8]);
                end
            end
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) push_good(8'($urandom_range(0, 255)));
            run_model();
            send_stim();
            compare_results($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
